traffic_phase_ctrl: RTL and testbench
=====================================

// Module: traffic_phase_ctrl
// PURPOSE
//  Sequences a bank of NumGen TCDM traffic generators through IDLE/WARMUP/MEASURE/DRAIN/DONE.
//  Gates request injection per phase, counts accepted requests and responses during the
//  measurement window, and tracks in-flight requests so drain completion is exact.
//  Sits in the testbench between the generators' request/response handshakes and the top-level run control.
// PARAMETERS
//  NumGen          4     number of traffic generators controlled
//  CntWidth        32    width of cycle-config inputs and statistic counters
//  MaxOutstanding  1024  max outstanding requests per generator; sizes the in-flight counter
//  InflWidth       (localparam) $clog2(NumGen*MaxOutstanding+1)
// PORTS
//  clk_i             in   1            clock
//  rst_ni            in   1            asynchronous reset, active-low
//  start_i           in   1            start a run; sampled in IDLE or DONE only
//  abort_i           in   1            stop injection early; WARMUP/MEASURE -> DRAIN
//  warmup_cycles_i   in   CntWidth     warmup length; latched on start
//  measure_cycles_i  in   CntWidth     measurement window length; latched on start
//  drain_timeout_i   in   CntWidth     max DRAIN cycles; 0 = no timeout; latched on start
//  gen_req_valid_i   in   NumGen       generator request valid
//  gen_req_ready_i   in   NumGen       interconnect request ready
//  gen_resp_valid_i  in   NumGen       response valid (response ready is always 1)
//  inject_en_o       out  NumGen       per-generator injection enable
//  phase_o           out  3            current phase (traffic_phase_e)
//  done_o            out  1            high while in DONE
//  timeout_o         out  1            sticky: DRAIN ended by timeout
//  underflow_o       out  1            sticky: response seen with in-flight==0
//  req_count_o       out  CntWidth     requests accepted during MEASURE
//  resp_count_o      out  CntWidth     responses received during MEASURE
//  inflight_o        out  InflWidth    current outstanding requests, all phases
// BEHAVIOUR
//  Reset: phase=IDLE, inject_en_o=0, done_o=0, timeout_o=0, underflow_o=0, all counters and latched config 0.
//  Accept: acc[i] = gen_req_valid_i[i] & gen_req_ready_i[i]. Counted in every phase, regardless of inject_en_o.
//  Per cycle: nreq=popcount(acc), nresp=popcount(gen_resp_valid_i).
//  inflight: next = inflight + nreq - nresp in one update. Simultaneous req+resp gives a net change.
//  If nresp > inflight+nreq: inflight clamps to 0 and underflow_o sets.
//  inflight saturates at its maximum. It is never cleared except by reset.
//  req_count_o/resp_count_o add nreq/nresp only on cycles with phase==MEASURE. Both wrap modulo 2^CntWidth.
//  inject_en_o = all ones in WARMUP and MEASURE, else 0. Decoded from the registered phase only (no comb path from inputs).
//  A generator's request already asserted when enable drops is still tracked if accepted.
//  cyc counter: cleared on every phase entry, incremented each cycle in the phase.
//  FSM transitions:
//   IDLE/DONE + start_i: latch config; clear req/resp counts, timeout_o, underflow_o.
//     Next state = WARMUP if warmup>0, else MEASURE if measure>0, else DRAIN.
//   WARMUP: when cyc==warmup-1 -> MEASURE (or DRAIN if measure==0). WARMUP lasts exactly warmup cycles.
//   MEASURE: when cyc==measure-1 -> DRAIN. MEASURE lasts exactly measure cycles.
//   abort_i in WARMUP/MEASURE -> DRAIN next cycle. abort_i has priority over the cycle-limit exit.
//   DRAIN: if next-inflight==0 -> DONE. Else if timeout!=0 and cyc==timeout-1 -> DONE with timeout_o=1.
//     If both hold in the same cycle: DONE with timeout_o=0.
//   DONE: holds until start_i. Statistics remain readable.
//  start_i and abort_i are ignored in all other states. Config inputs are ignored except on start.
//  Async reset mid-run: immediate return to reset values. Generators see inject_en_o=0 at once.
// STRUCTURE
//  Shared package traffic_pkg: typedef enum logic[2:0] traffic_phase_e {IDLE,WARMUP,MEASURE,DRAIN,DONE};
//   plus a traffic_cfg_t struct (warmup, measure, drain_timeout).
//  Instantiate common_cells popcount twice (requests, responses).
//  Single FSM + counters otherwise; no further sub-modules. Flops via registers.svh macros.
// TESTING
//  1. warmup=10, measure=100, 4 gens, valid=ready=1, 1-cycle resp:
//     MEASURE exactly 100 cycles; req_count=400, resp_count=400; DONE 1 cycle after DRAIN entry.
//  2. warmup=0, measure=0, start -> DRAIN then DONE next cycle; inject_en_o never asserted, counts 0.
//  3. Responses withheld in DRAIN, timeout=20 -> DONE exactly 20 cycles after DRAIN entry;
//     timeout_o=1; inflight_o unchanged.
//  4. Same cycle 3 req accepts + 2 resps with inflight=5 -> inflight=6. Resp with inflight=0 -> stays 0, underflow_o=1.
//  5. abort_i at MEASURE cycle 37 -> DRAIN next cycle, req_count reflects only 37 cycles.
//     Next start_i clears counts and sticky flags.
//  6. rst_ni low mid-MEASURE -> same-cycle inject_en_o=0, phase IDLE, all counters 0.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared types for the traffic phase controller: the run phase
//                encoding and the configuration latched when a run starts.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Width of the stored run configuration fields.
    localparam int unsigned CFG_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        MEASURE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } traffic_phase_e;

    typedef struct packed {
        logic [CFG_WIDTH-1:0] warmup;
        logic [CFG_WIDTH-1:0] measure;
        logic [CFG_WIDTH-1:0] drain_timeout;
    } traffic_cfg_t;

endpackage
`default_nettype wire

// File: rtl/traffic_phase_ctrl_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_ctrl_popcount
//  Description : Combinational population count of a bit vector.
//  Ports       : i_data  - vector to count
//                o_count - number of set bits in i_data
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl_popcount #(
    parameter int unsigned INPUT_WIDTH = 4,
    localparam int unsigned COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
    input  logic [INPUT_WIDTH-1:0] i_data,
    output logic [COUNT_WIDTH-1:0] o_count
);

    logic [COUNT_WIDTH-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < int'(INPUT_WIDTH); i++) begin
            w_sum = w_sum + COUNT_WIDTH'(i_data[i]);
        end
    end

    assign o_count = w_sum;

endmodule
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_ctrl
//  Description : Sequences a bank of traffic generators through
//                IDLE/WARMUP/MEASURE/DRAIN/DONE, gates their injection,
//                counts requests/responses inside the measurement window and
//                tracks outstanding requests so the drain ends exactly.
//  Ports       : clk_i, rst_ni           - clock, async active-low reset
//                start_i, abort_i        - run control
//                *_cycles_i, drain_timeout_i - run config, latched on start
//                gen_req_valid_i/ready_i - request handshakes per generator
//                gen_resp_valid_i        - responses per generator
//                inject_en_o             - per-generator injection enable
//                phase_o, done_o         - current phase / DONE indicator
//                timeout_o, underflow_o  - sticky status flags
//                req_count_o, resp_count_o, inflight_o - statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned NumGen         = 4,
    parameter int unsigned CntWidth       = 32,
    parameter int unsigned MaxOutstanding = 1024,
    localparam int unsigned InflWidth     = $clog2(NumGen * MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [CntWidth-1:0]  warmup_cycles_i,
    input  logic [CntWidth-1:0]  measure_cycles_i,
    input  logic [CntWidth-1:0]  drain_timeout_i,
    input  logic [NumGen-1:0]    gen_req_valid_i,
    input  logic [NumGen-1:0]    gen_req_ready_i,
    input  logic [NumGen-1:0]    gen_resp_valid_i,
    output logic [NumGen-1:0]    inject_en_o,
    output traffic_phase_e       phase_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic                 underflow_o,
    output logic [CntWidth-1:0]  req_count_o,
    output logic [CntWidth-1:0]  resp_count_o,
    output logic [InflWidth-1:0] inflight_o
);

    localparam int unsigned c_POP_W = $clog2(NumGen + 1);
    localparam int unsigned c_SUM_W = InflWidth + 1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    traffic_phase_e       r_phase;
    traffic_cfg_t         r_cfg;
    logic [CntWidth-1:0]  r_cyc;
    logic [CntWidth-1:0]  r_req_cnt;
    logic [CntWidth-1:0]  r_resp_cnt;
    logic [InflWidth-1:0] r_inflight;
    logic                 r_timeout;
    logic                 r_underflow;

    // ------------------------------------------------------------------------
    // Per-cycle request/response counts
    // ------------------------------------------------------------------------
    logic [NumGen-1:0]    w_acc;
    logic [c_POP_W-1:0]   w_nreq;
    logic [c_POP_W-1:0]   w_nresp;

    // Accepts are tracked regardless of enable so a request held across the
    // enable drop is never lost from the in-flight count.
    assign w_acc = gen_req_valid_i & gen_req_ready_i;

    traffic_phase_ctrl_popcount #(
        .INPUT_WIDTH (NumGen)
    ) u_pop_req (
        .i_data  (w_acc),
        .o_count (w_nreq)
    );

    traffic_phase_ctrl_popcount #(
        .INPUT_WIDTH (NumGen)
    ) u_pop_resp (
        .i_data  (gen_resp_valid_i),
        .o_count (w_nresp)
    );

    // ------------------------------------------------------------------------
    // In-flight update: net change in one step, clamp at 0, saturate at max
    // ------------------------------------------------------------------------
    logic [c_SUM_W-1:0]   w_infl_sum;
    logic [c_SUM_W-1:0]   w_infl_diff;
    logic [InflWidth-1:0] w_infl_next;
    logic                 w_underflow;

    always_comb begin
        w_infl_sum  = {1'b0, r_inflight} + c_SUM_W'(w_nreq);
        w_infl_diff = '0;
        w_infl_next = '0;
        w_underflow = 1'b0;
        if (c_SUM_W'(w_nresp) > w_infl_sum) begin
            w_underflow = 1'b1;
        end else begin
            w_infl_diff = w_infl_sum - c_SUM_W'(w_nresp);
            if (w_infl_diff[InflWidth]) begin
                w_infl_next = '1;
            end else begin
                w_infl_next = w_infl_diff[InflWidth-1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Phase FSM: next-state logic
    // ------------------------------------------------------------------------
    logic [CntWidth-1:0] w_warmup;
    logic [CntWidth-1:0] w_measure;
    logic [CntWidth-1:0] w_drain_to;
    traffic_phase_e      w_phase_next;
    logic                w_start;
    logic                w_timeout_set;

    assign w_warmup   = CntWidth'(r_cfg.warmup);
    assign w_measure  = CntWidth'(r_cfg.measure);
    assign w_drain_to = CntWidth'(r_cfg.drain_timeout);

    always_comb begin
        w_phase_next  = r_phase;
        w_start       = 1'b0;
        w_timeout_set = 1'b0;
        unique case (r_phase)
            IDLE, DONE: begin
                if (start_i) begin
                    w_start = 1'b1;
                    // Zero-length phases are skipped using the incoming config.
                    if (warmup_cycles_i != '0) begin
                        w_phase_next = WARMUP;
                    end else if (measure_cycles_i != '0) begin
                        w_phase_next = MEASURE;
                    end else begin
                        w_phase_next = DRAIN;
                    end
                end
            end
            WARMUP: begin
                if (abort_i) begin
                    w_phase_next = DRAIN;
                end else if (r_cyc == w_warmup - CntWidth'(1)) begin
                    w_phase_next = (w_measure != '0) ? MEASURE : DRAIN;
                end
            end
            MEASURE: begin
                if (abort_i || (r_cyc == w_measure - CntWidth'(1))) begin
                    w_phase_next = DRAIN;
                end
            end
            DRAIN: begin
                // A clean drain wins over a coincident timeout.
                if (w_infl_next == '0) begin
                    w_phase_next = DONE;
                end else if ((w_drain_to != '0) &&
                             (r_cyc == w_drain_to - CntWidth'(1))) begin
                    w_phase_next  = DONE;
                    w_timeout_set = 1'b1;
                end
            end
            default: begin
                w_phase_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Phase FSM: state register and per-phase cycle counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_phase <= IDLE;
            r_cyc   <= '0;
        end else begin
            r_phase <= w_phase_next;
            r_cyc   <= (w_phase_next != r_phase) ? '0 : r_cyc + CntWidth'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Config latch, statistics and sticky flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg       <= '0;
            r_req_cnt   <= '0;
            r_resp_cnt  <= '0;
            r_inflight  <= '0;
            r_timeout   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_inflight <= w_infl_next;

            if (w_start) begin
                r_cfg <= '{warmup:        CFG_WIDTH'(warmup_cycles_i),
                           measure:       CFG_WIDTH'(measure_cycles_i),
                           drain_timeout: CFG_WIDTH'(drain_timeout_i)};
                r_req_cnt  <= '0;
                r_resp_cnt <= '0;
                r_timeout  <= 1'b0;
            end else begin
                if (r_phase == MEASURE) begin
                    r_req_cnt  <= r_req_cnt  + CntWidth'(w_nreq);
                    r_resp_cnt <= r_resp_cnt + CntWidth'(w_nresp);
                end
                if (w_timeout_set) begin
                    r_timeout <= 1'b1;
                end
            end

            // An underflow on the start cycle itself is still reported.
            if (w_underflow) begin
                r_underflow <= 1'b1;
            end else if (w_start) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // ------------------------------------------------------------------------
    assign inject_en_o  = {NumGen{(r_phase == WARMUP) || (r_phase == MEASURE)}};
    assign phase_o      = r_phase;
    assign done_o       = (r_phase == DONE);
    assign timeout_o    = r_timeout;
    assign underflow_o  = r_underflow;
    assign req_count_o  = r_req_cnt;
    assign resp_count_o = r_resp_cnt;
    assign inflight_o   = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_phase_ctrl
//  Description : Self-checking bench for traffic_phase_ctrl. A reference model
//                tracks the run as "cycles left in phase" plus plain integer
//                statistics; its expected output snapshot is queued every
//                cycle and a monitor compares it with the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_ctrl;
    import traffic_pkg::*;

    localparam int NG      = 4;
    localparam int INFL_W  = $clog2(NG * 1024 + 1);
    localparam int INFL_MAX = (1 << INFL_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_i, abort_i;
    logic [31:0]       warmup_cycles_i, measure_cycles_i, drain_timeout_i;
    logic [NG-1:0]     gen_req_valid_i, gen_req_ready_i, gen_resp_valid_i;
    logic [NG-1:0]     inject_en_o;
    traffic_phase_e    phase_o;
    logic              done_o, timeout_o, underflow_o;
    logic [31:0]       req_count_o, resp_count_o;
    logic [INFL_W-1:0] inflight_o;

    traffic_phase_ctrl #(.NumGen(NG), .CntWidth(32), .MaxOutstanding(1024)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .warmup_cycles_i(warmup_cycles_i), .measure_cycles_i(measure_cycles_i),
        .drain_timeout_i(drain_timeout_i), .gen_req_valid_i(gen_req_valid_i),
        .gen_req_ready_i(gen_req_ready_i), .gen_resp_valid_i(gen_resp_valid_i),
        .inject_en_o(inject_en_o), .phase_o(phase_o), .done_o(done_o),
        .timeout_o(timeout_o), .underflow_o(underflow_o), .req_count_o(req_count_o),
        .resp_count_o(resp_count_o), .inflight_o(inflight_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    traffic_phase_e m_phase;
    longint m_left, m_elapsed, m_wu, m_me, m_to;
    int     m_infl;
    logic [31:0] m_req, m_resp;
    bit     m_tof, m_uf;
    int     out_cnt [NG];   // requests each generator still expects answered

    typedef struct {
        logic [2:0]    phase;
        logic [NG-1:0] inj;
        logic          done, tof, uf;
        logic [31:0]   req, resp;
        int            infl;
    } snap_t;
    snap_t exp_q [$];

    task automatic enter(input traffic_phase_e p);
        m_phase = p;
        if (p == WARMUP)  m_left = m_wu;
        if (p == MEASURE) m_left = m_me;
        if (p == DRAIN)   m_elapsed = 0;
    endtask

    task automatic model_reset();
        m_phase = IDLE; m_left = 0; m_elapsed = 0; m_wu = 0; m_me = 0; m_to = 0;
        m_infl = 0; m_req = 0; m_resp = 0; m_tof = 0; m_uf = 0;
        for (int i = 0; i < NG; i++) out_cnt[i] = 0;
    endtask

    task automatic model_step(input bit st, ab, input logic [31:0] wu, me, to, input int nreq, nresp);
        int nxt;
        bit uf_now;
        uf_now = 0;
        if (nresp > m_infl + nreq) begin
            nxt = 0; uf_now = 1;
        end else begin
            nxt = m_infl + nreq - nresp;
        end
        if (nxt > INFL_MAX) nxt = INFL_MAX;
        if (m_phase == MEASURE) begin
            m_req  = m_req  + 32'(nreq);
            m_resp = m_resp + 32'(nresp);
        end
        case (m_phase)
            IDLE, DONE: if (st) begin
                m_wu = longint'(wu); m_me = longint'(me); m_to = longint'(to);
                m_req = 0; m_resp = 0; m_tof = 0; m_uf = 0;
                if (m_wu > 0) enter(WARMUP);
                else if (m_me > 0) enter(MEASURE);
                else enter(DRAIN);
            end
            WARMUP: if (ab) enter(DRAIN);
                    else begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_me > 0) enter(MEASURE); else enter(DRAIN);
                        end
                    end
            MEASURE: if (ab) enter(DRAIN);
                     else begin
                         m_left--;
                         if (m_left == 0) enter(DRAIN);
                     end
            DRAIN: begin
                m_elapsed++;
                if (nxt == 0) enter(DONE);
                else if (m_to != 0 && m_elapsed == m_to) begin
                    enter(DONE); m_tof = 1;
                end
            end
            default: ;
        endcase
        m_infl = nxt;
        if (uf_now) m_uf = 1;
    endtask

    task automatic push_snapshot();
        snap_t s;
        s.phase = m_phase;
        s.inj   = (m_phase == WARMUP || m_phase == MEASURE) ? '1 : '0;
        s.done  = (m_phase == DONE);
        s.tof = m_tof; s.uf = m_uf; s.req = m_req; s.resp = m_resp; s.infl = m_infl;
        exp_q.push_back(s);
    endtask

    // ---------------- monitor ----------------
    initial begin
        snap_t s;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                check("phase",     64'(phase_o),      64'(s.phase));
                check("inject_en", 64'(inject_en_o),  64'(s.inj));
                check("done",      64'(done_o),       64'(s.done));
                check("timeout",   64'(timeout_o),    64'(s.tof));
                check("underflow", 64'(underflow_o),  64'(s.uf));
                check("req_count", 64'(req_count_o),  64'(s.req));
                check("resp_count",64'(resp_count_o), 64'(s.resp));
                check("inflight",  64'(inflight_o),   64'(s.infl));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic st, ab, input logic [31:0] wu, me, to,
                         input logic [NG-1:0] v, r, rv);
        start_i = st; abort_i = ab;
        warmup_cycles_i = wu; measure_cycles_i = me; drain_timeout_i = to;
        gen_req_valid_i = v; gen_req_ready_i = r; gen_resp_valid_i = rv;
        for (int i = 0; i < NG; i++) begin
            out_cnt[i] += int'(v[i] & r[i]) - int'(rv[i]);
            if (out_cnt[i] < 0) out_cnt[i] = 0;
        end
        @(posedge clk_i);
        #2;
        model_step(st, ab, wu, me, to, $countones(v & r), $countones(rv));
        push_snapshot();
        start_i = 0; abort_i = 0;
        gen_req_valid_i = '0; gen_req_ready_i = '0; gen_resp_valid_i = '0;
    endtask

    task automatic stim(input logic st, ab, input logic [31:0] wu, me, to,
                        input int p_v, p_r, p_rs, input bit hold);
        logic [NG-1:0] v, r, rv;
        bit inj;
        inj = (m_phase == WARMUP) || (m_phase == MEASURE);
        for (int i = 0; i < NG; i++) begin
            v[i]  = inj && (int'($urandom_range(99)) < p_v);
            r[i]  = int'($urandom_range(99)) < p_r;
            rv[i] = (out_cnt[i] > 0) && !(hold && m_phase == DRAIN) &&
                    (int'($urandom_range(99)) < p_rs);
        end
        drive(st, ab, wu, me, to, v, r, rv);
    endtask

    // Observations of the DUT during the latest run.
    int ob_t, ob_meas, ob_drain_t, ob_done_t, ob_infl_drain;
    bit ob_en;

    task automatic observe();
        ob_t++;
        if (phase_o == MEASURE) ob_meas++;
        if (phase_o == DRAIN && ob_drain_t < 0) begin
            ob_drain_t = ob_t; ob_infl_drain = int'(inflight_o);
        end
        if (phase_o == DONE && ob_done_t < 0) ob_done_t = ob_t;
        if (|inject_en_o) ob_en = 1;
    endtask

    task automatic do_reset();
        #4;
        check("pre_reset_inject", 64'(inject_en_o), 64'({NG{1'b1}}));
        rst_ni = 0;
        #1;
        check("rst_inject",   64'(inject_en_o),  64'(0));
        check("rst_phase",    64'(phase_o),      64'(IDLE));
        check("rst_req",      64'(req_count_o),  64'(0));
        check("rst_resp",     64'(resp_count_o), 64'(0));
        check("rst_inflight", 64'(inflight_o),   64'(0));
        check("rst_done",     64'(done_o),       64'(0));
        model_reset();
        exp_q.delete();
        @(posedge clk_i);
        #2;
        rst_ni = 1;
    endtask

    task automatic run(input int wu, me, to, abort_at, reset_at, p_v, p_r, p_rs,
                       input bit hold, noise, chk_clear);
        int meas_idx, budget;
        bit ab, st, was_active;
        logic [31:0] nw, nm, nt;
        ob_t = 0; ob_meas = 0; ob_drain_t = -1; ob_done_t = -1; ob_infl_drain = 0; ob_en = 0;
        meas_idx = 0; budget = 0;
        stim(1, 0, wu, me, to, p_v, p_r, p_rs, hold);
        observe();
        if (chk_clear) begin
            check("start_clr_req",  64'(req_count_o),  64'(0));
            check("start_clr_resp", 64'(resp_count_o), 64'(0));
            check("start_clr_to",   64'(timeout_o),    64'(0));
            check("start_clr_uf",   64'(underflow_o),  64'(0));
        end
        while (m_phase != DONE && budget < 3000) begin
            ab = 0; st = 0; nw = wu; nm = me; nt = to;
            if (m_phase == MEASURE) begin
                if (reset_at > 0 && meas_idx == reset_at) begin
                    do_reset();
                    return;
                end
                if (abort_at > 0 && meas_idx == abort_at - 1) ab = 1;
                meas_idx++;
            end
            if (noise) begin
                st = ($urandom_range(19) == 0);
                if ($urandom_range(49) == 0) ab = 1;
                nw = $urandom; nm = $urandom; nt = $urandom;
            end
            was_active = (m_phase == WARMUP) || (m_phase == MEASURE);
            stim(st, ab, nw, nm, nt, p_v, p_r, p_rs, hold);
            observe();
            if (ab && was_active) check("abort_to_drain", 64'(phase_o), 64'(DRAIN));
            budget++;
        end
        check("run_reaches_done", 64'(done_o), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wu, me, to, ab_at;
        bit hold;
        rst_ni = 0; start_i = 0; abort_i = 0;
        warmup_cycles_i = 0; measure_cycles_i = 0; drain_timeout_i = 0;
        gen_req_valid_i = 0; gen_req_ready_i = 0; gen_resp_valid_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #2;
        rst_ni = 1;
        push_snapshot();

        // In-flight arithmetic while idle: 4, 5, then 3 req + 2 resp -> 6.
        drive(0, 0, 0, 0, 0, 4'hF, 4'hF, 4'h0);
        drive(0, 0, 0, 0, 0, 4'h1, 4'h1, 4'h0);
        check("t4_inflight5", 64'(inflight_o), 64'(5));
        drive(0, 0, 0, 0, 0, 4'h7, 4'hF, 4'h3);
        check("t4_inflight6", 64'(inflight_o), 64'(6));
        drive(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF);
        drive(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h5);
        check("t4_inflight0", 64'(inflight_o), 64'(0));
        drive(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h2);
        check("t4_clamp0", 64'(inflight_o), 64'(0));
        check("t4_underflow", 64'(underflow_o), 64'(1));

        // Full-rate run with one-cycle responses.
        run(10, 100, 0, 0, 0, 100, 100, 100, 0, 0, 0);
        check("t1_measure_len", 64'(ob_meas), 64'(100));
        check("t1_done_delay", 64'(ob_done_t - ob_drain_t), 64'(1));
        check("t1_req", 64'(req_count_o), 64'(400));
        check("t1_resp", 64'(resp_count_o), 64'(400));
        check("t1_uf_cleared", 64'(underflow_o), 64'(0));

        // Zero-length warmup and measure.
        run(0, 0, 0, 0, 0, 100, 100, 100, 0, 0, 0);
        check("t2_no_inject", 64'(ob_en), 64'(0));
        check("t2_done_delay", 64'(ob_done_t - ob_drain_t), 64'(1));
        check("t2_req", 64'(req_count_o), 64'(0));
        check("t2_resp", 64'(resp_count_o), 64'(0));

        // Responses withheld in DRAIN, timeout 20.
        run(5, 20, 20, 0, 0, 100, 100, 100, 1, 0, 0);
        check("t3_done_delay", 64'(ob_done_t - ob_drain_t), 64'(20));
        check("t3_timeout", 64'(timeout_o), 64'(1));
        check("t3_infl_drain", 64'(ob_infl_drain), 64'(4));
        check("t3_infl_done", 64'(inflight_o), 64'(4));

        // Abort on the 37th measurement cycle.
        run(10, 100, 0, 37, 0, 100, 100, 100, 0, 0, 0);
        check("t5_req", 64'(req_count_o), 64'(148));
        drive(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1);
        check("t5_underflow", 64'(underflow_o), 64'(1));

        // Next start clears statistics and flags; reset lands mid-MEASURE.
        run(3, 50, 0, 0, 20, 100, 100, 100, 0, 0, 1);

        // Randomised runs with noise on ignored inputs.
        for (int k = 0; k < 10; k++) begin
            wu = int'($urandom_range(15));
            me = int'($urandom_range(60));
            to = int'($urandom_range(30));
            hold = (to != 0) && ($urandom_range(1) == 1);
            ab_at = ($urandom_range(2) == 0) ? int'($urandom_range(me + 1, 1)) : 0;
            run(wu, me, to, ab_at, 0,
                int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                int'($urandom_range(100, 30)), hold, 1, 0);
        end

        repeat (2) @(posedge clk_i);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
